// File: rtl/lifo_stack_if.sv
// Handshake/data bundle for lifo_stack. Error signals (ovf, udf, clr_err)
// are present only when LIFO_ERR_EN is defined.
interface lifo_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) ();
    logic                     push;
    logic                     pop;
    logic [WIDTH-1:0]         din;
    logic [WIDTH-1:0]         dout;
    logic                     dout_valid;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
`ifdef LIFO_ERR_EN
    logic                     ovf;
    logic                     udf;
    logic                     clr_err;
`endif

    modport master (
        output push, pop, din,
`ifdef LIFO_ERR_EN
        output clr_err,
        input  ovf, udf,
`endif
        input  dout, dout_valid, count, full, empty, almost_full
    );

    modport slave (
        input  push, pop, din,
`ifdef LIFO_ERR_EN
        input  clr_err,
        output ovf, udf,
`endif
        output dout, dout_valid, count, full, empty, almost_full
    );
endinterface

// File: rtl/lifo_stack.sv
// Register-based LIFO stack with one-cycle registered pop data.
// Optional sticky overflow/underflow flags when LIFO_ERR_EN is defined.
module lifo_stack #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    lifo_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [AW-1:0]    w_top;
    logic [AW-1:0]    w_wr_idx;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = bus.pop && !w_empty;
    // A push on a full stack is still taken when it pairs with a pop (top replace).
    assign w_push_ok = bus.push && (!w_full || w_pop_ok);
    // Low bits wrap so count==DEPTH still addresses DEPTH-1 correctly.
    assign w_top     = r_count[AW-1:0] - AW'(1);
    assign w_wr_idx  = w_pop_ok ? w_top : r_count[AW-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push_ok)
            r_mem[w_wr_idx] <= bus.din;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_pop_ok;
            if (w_pop_ok)
                r_dout <= r_mem[w_top];
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + CW'(1);
            else if (w_pop_ok && !w_push_ok)
                r_count <= r_count - CW'(1);
        end
    end

    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = (r_count >= CW'(AFULL_TH));

`ifdef LIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    // Setting beats clr_err so an error in the clearing cycle is not lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.push && !w_push_ok)
                r_ovf <= 1'b1;
            else if (bus.clr_err)
                r_ovf <= 1'b0;
            if (bus.pop && w_empty)
                r_udf <= 1'b1;
            else if (bus.clr_err)
                r_udf <= 1'b0;
        end
    end

    assign bus.ovf = r_ovf;
    assign bus.udf = r_udf;
`endif
endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 16: number of stack entries, a power of two, at least 2.
REQ-003 Parameter AFULL_TH, default DEPTH-2: count at or above which almost_full asserts, in the range 1..DEPTH.
REQ-004 Clocking is decided: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 push  input  1  write request for din.
REQ-008 pop  input  1  read request for the top entry.
REQ-009 din  input  WIDTH  push data.
REQ-010 dout  output  WIDTH  registered popped data.
REQ-011 dout_valid  output  1  one-cycle pulse, dout updated this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 full, empty, almost_full  output  1 each  status flags.
REQ-014 ovf, udf, clr_err  output, output, input  1 each  present only under LIFO_ERR_EN (see REQ-029).

Function
REQ-015 Storage: DEPTH x WIDTH array; entry index = stack position; top entry at index count-1.
REQ-016 Flags: combinational from registered count only.
- full = (count == DEPTH)
- empty = (count == 0)
- almost_full = (count >= AFULL_TH)
REQ-017 Push only, not full: mem[count] <= din; count <= count+1.
REQ-018 Pop only, not empty: dout <= mem[count-1]; dout_valid <= 1 next cycle; count <= count-1.
REQ-019 Push and pop together, not empty (including full): replace top.
- dout <= old mem[count-1]
- mem[count-1] <= din
- dout_valid <= 1; count unchanged
REQ-020 Push and pop together, empty: push performed (count becomes 1); pop rejected; dout and dout_valid behave as for no pop.
REQ-021 Push only, full: rejected; memory and count unchanged.
REQ-022 Pop only, empty: rejected; count unchanged; dout holds; dout_valid 0.
REQ-023 No accepted pop in a cycle: dout holds its previous value; dout_valid 0 in the following cycle.
REQ-024 Read latency: exactly one cycle from the accepting edge to dout/dout_valid.
REQ-025 count never wraps; it is always within 0..DEPTH.

Reset
REQ-026 rst high at a clock edge takes priority over push/pop in the same cycle: count=0, dout=0, dout_valid=0, full=0, empty=1, almost_full=0, ovf=0, udf=0.
REQ-027 Memory contents are not cleared by reset; entries are unreadable until re-pushed.
REQ-028 Reset asserted mid-operation discards all stacked data within one cycle.

Configuration
REQ-029 Macro LIFO_ERR_EN defined: ports ovf, udf and clr_err exist.
- ovf sets sticky on a rejected push (REQ-021).
- udf sets sticky on a rejected pop (REQ-020, REQ-022).
- Both clear when rst=1 or clr_err=1; set takes priority over clr_err in the same cycle.
REQ-030 Macro LIFO_ERR_EN undefined: ovf, udf and clr_err ports and logic are absent; all other behaviour is identical.

Verification
REQ-031 DEPTH=4: reset; push A1,A2,A3 -> count=3, almost_full=1 (AFULL_TH=2), empty=0.
REQ-032 Stack holds A1,A2,A3; pop x3 -> dout A3,A2,A1 on consecutive cycles with dout_valid=1; then empty=1, count=0.
REQ-033 Stack full (4 entries); push 0xFF -> count stays 4, top unchanged; with LIFO_ERR_EN, ovf=1 until clr_err.
REQ-034 count=2, top=0x22; push 0x55 and pop together -> dout=0x22, count=2, next pop returns 0x55.
REQ-035 Empty stack; push and pop together with din=0x11 -> count=1, dout_valid=0, udf=1 (LIFO_ERR_EN); then pop -> dout=0x11.
REQ-036 count=3; rst=1 with push=1 -> next cycle count=0, empty=1, dout=0, dout_valid=0.
